// File: rtl/digsys_pkg.sv
// Shared constants and types for the byte-to-word assembler and the
// downstream 32-bit ones-counter stage.
//   WORD_W / BYTE_W / LANES : datapath geometry
//   asm_state_e             : assembler control states
//   word_t                  : assembled word with its byte count and frame flag
package digsys_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int LANES  = WORD_W / BYTE_W;
  localparam int IDX_W  = $clog2(LANES);
  localparam int NB_W   = $clog2(LANES) + 1;

  typedef enum logic {
    ST_FILL,   // output empty or draining
    ST_STALL   // output full, completing byte waiting on out_ready
  } asm_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [NB_W-1:0]   nbytes;
    logic              last;
  } word_t;
endpackage

// File: rtl/word_holdreg.sv
// Output register for assembled words with valid/ready hold.
//   clk, rst_n    : clock, async active-low reset
//   load_i        : capture word_i (caller guarantees the slot is free or draining)
//   word_i        : word to capture
//   out_ready_i   : downstream consumes the held word this cycle
//   word_o        : held word (stable while valid_o & ~out_ready_i)
//   valid_o       : word_o holds a complete word
module word_holdreg
  import digsys_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  word_t word_i,
  input  logic  out_ready_i,
  output word_t word_o,
  output logic  valid_o
);
  word_t word_q, word_d;
  logic  valid_q, valid_d;

  // A load wins over a consume so a word arriving on the draining edge
  // keeps valid high with no bubble.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    if (load_i) begin
      word_d  = word_i;
      valid_d = 1'b1;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_o  = word_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/word_assembler.sv
// Packs a byte stream into 32-bit words for the ones-counter stage.
//   LSB_FIRST  : 1 = first byte in D[7:0], 0 = first byte in D[31:24]
//   clk, rst_n : clock, async active-low reset
//   in_data/in_valid/in_last/in_ready : byte input handshake
//   D/out_nbytes/out_last/out_valid/out_ready : word output handshake
module word_assembler
  import digsys_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] D,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_nbytes,
  output logic              out_last
);
  asm_state_e        state_q, state_d;
  logic [WORD_W-1:0] fill_q, fill_d, merged;
  logic [IDX_W-1:0]  idx_q, idx_d, lane;
  logic              completing, blocked, accept, done;
  word_t             hold_in, hold_out;

  // A byte only stalls when it would complete a word and the output slot
  // cannot drain this edge; in_valid deliberately plays no part.
  assign completing = (idx_q == IDX_W'(LANES - 1)) | in_last;
  assign blocked    = out_valid & ~out_ready & completing;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b1;
    case (state_q)
      ST_FILL: begin
        in_ready = ~blocked;
        if (in_valid && blocked) state_d = ST_STALL;
      end
      ST_STALL: begin
        in_ready = ~blocked;
        if (out_ready) state_d = ST_FILL;
      end
    endcase
  end

  assign accept = in_valid & in_ready;
  assign done   = accept & completing;

  // MSB-first order mirrors the lane: 3 - idx == ~idx for a 2-bit index.
  always_comb begin
    lane   = (LSB_FIRST != 0) ? idx_q : ~idx_q;
    merged = fill_q;
    merged[lane*BYTE_W +: BYTE_W] = in_data;
    fill_d = fill_q;
    idx_d  = idx_q;
    if (done) begin
      fill_d = '0;
      idx_d  = '0;
    end else if (accept) begin
      fill_d = merged;
      idx_d  = idx_q + 1'b1;
    end
  end

  // Unfilled lanes of merged are already zero because fill clears on completion.
  always_comb begin
    hold_in.data   = merged;
    hold_in.nbytes = NB_W'(idx_q) + NB_W'(1);
    hold_in.last   = in_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      fill_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
    end
  end

  word_holdreg u_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (done),
    .word_i      (hold_in),
    .out_ready_i (out_ready),
    .word_o      (hold_out),
    .valid_o     (out_valid)
  );

  assign D          = hold_out.data;
  assign out_nbytes = hold_out.nbytes;
  assign out_last   = hold_out.last;
endmodule

// File: tb/tb_word_assembler.sv
module tb_word_assembler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        vin, lin, rdy;
  // a_* : LSB_FIRST=1 instance, b_* : LSB_FIRST=0 instance, shared inputs
  logic        a_ir, a_ov, a_last, b_ir, b_ov, b_last;
  logic [31:0] a_d, b_d;
  logic [2:0]  a_nb, b_nb;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  word_assembler #(.LSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(vin), .in_last(lin),
    .in_ready(a_ir), .D(a_d), .out_valid(a_ov), .out_ready(rdy),
    .out_nbytes(a_nb), .out_last(a_last));

  word_assembler #(.LSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(vin), .in_last(lin),
    .in_ready(b_ir), .D(b_d), .out_valid(b_ov), .out_ready(rdy),
    .out_nbytes(b_nb), .out_last(b_last));

  typedef struct {
    logic [7:0]  d;
    logic        v, l, r;
    logic        ir, ov;
    logic [31:0] da, db;
    logic [2:0]  nb;
    logic        last;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic [7:0] d, input logic v, l, r, ir, ov,
                              input logic [31:0] da, db, input logic [2:0] nb,
                              input logic last);
    vec_t t;
    t.d = d; t.v = v; t.l = l; t.r = r; t.ir = ir; t.ov = ov;
    t.da = da; t.db = db; t.nb = nb; t.last = last;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic setin(input logic [7:0] d, input logic v, l, r);
    din = d; vin = v; lin = l; rdy = r;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] da, db,
                          input logic [2:0] nb, input logic last);
    chk({tag, " a_ov"}, 32'(a_ov), 32'd1);
    chk({tag, " b_ov"}, 32'(b_ov), 32'd1);
    chk({tag, " a_D"}, a_d, da);
    chk({tag, " b_D"}, b_d, db);
    chk({tag, " a_nb"}, 32'(a_nb), 32'(nb));
    chk({tag, " b_nb"}, 32'(b_nb), 32'(nb));
    chk({tag, " a_last"}, 32'(a_last), 32'(last));
    chk({tag, " b_last"}, 32'(b_last), 32'(last));
  endtask

  initial begin
    // rows: inputs this cycle, outputs observed before this cycle's edge
    tbl[0]  = mk(8'h11, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(8'h22, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(8'h33, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(8'h44, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(8'h00, 0, 0, 1, 1, 1, 32'h44332211, 32'h11223344, 4, 0);
    tbl[5]  = mk(8'h00, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[6]  = mk(8'hAA, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[7]  = mk(8'hBB, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    tbl[8]  = mk(8'h00, 0, 0, 1, 1, 1, 32'h0000BBAA, 32'hAABB0000, 2, 1);
    tbl[9]  = mk(8'h00, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++)
      tbl[10+k] = mk(8'(k + 1), 1, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[22] = mk(8'h00, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[23] = mk(8'h00, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[14].ov = 1; tbl[14].da = 32'h04030201; tbl[14].db = 32'h01020304; tbl[14].nb = 4;
    tbl[18].ov = 1; tbl[18].da = 32'h08070605; tbl[18].db = 32'h05060708; tbl[18].nb = 4;
    tbl[22].ov = 1; tbl[22].da = 32'h0C0B0A09; tbl[22].db = 32'h090A0B0C; tbl[22].nb = 4;

    // reset state
    rst_n = 1'b1;
    setin(8'h00, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst a_ov", 32'(a_ov), 0);
    chk("rst a_D", a_d, 0);
    chk("rst b_D", b_d, 0);
    chk("rst a_nb", 32'(a_nb), 0);
    chk("rst a_ir", 32'(a_ir), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      setin(tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].r);
      #2;
      chk($sformatf("row%0d a_ir", i), 32'(a_ir), 32'(tbl[i].ir));
      chk($sformatf("row%0d b_ir", i), 32'(b_ir), 32'(tbl[i].ir));
      chk($sformatf("row%0d a_ov", i), 32'(a_ov), 32'(tbl[i].ov));
      chk($sformatf("row%0d b_ov", i), 32'(b_ov), 32'(tbl[i].ov));
      if (tbl[i].ov)
        chk_word($sformatf("row%0d", i), tbl[i].da, tbl[i].db, tbl[i].nb, tbl[i].last);
      @(negedge clk);
    end

    // backpressure: first word held, bytes 5-7 accepted, byte 8 stalls
    for (int k = 1; k <= 4; k++) begin
      setin(8'(k), 1, 0, 0);
      #2 chk("bp fill ir", 32'(a_ir), 1);
      @(negedge clk);
    end
    for (int k = 5; k <= 7; k++) begin
      setin(8'(k), 1, 0, 0);
      #2;
      chk("bp b5-7 a_ir", 32'(a_ir), 1);
      chk("bp b5-7 b_ir", 32'(b_ir), 1);
      chk_word("bp hold", 32'h04030201, 32'h01020304, 4, 0);
      @(negedge clk);
    end
    repeat (3) begin
      setin(8'h08, 1, 0, 0);
      #2;
      chk("bp b8 a_ir", 32'(a_ir), 0);
      chk("bp b8 b_ir", 32'(b_ir), 0);
      chk_word("bp stall", 32'h04030201, 32'h01020304, 4, 0);
      @(negedge clk);
    end
    setin(8'h08, 1, 0, 1);
    #2 chk("bp release ir", 32'(a_ir), 1);
    @(negedge clk);
    setin(8'h00, 0, 0, 1);
    #2 chk_word("bp word2", 32'h08070605, 32'h05060708, 4, 0);
    @(negedge clk);
    setin(8'h00, 0, 0, 1);
    #2 chk("bp drained ov", 32'(a_ov), 0);
    @(negedge clk);

    // single-byte frame, then in_ready dependence on in_last only
    setin(8'h5A, 1, 1, 0);
    #2 chk("one ir", 32'(a_ir), 1);
    @(negedge clk);
    setin(8'h77, 1, 1, 0);
    #2;
    chk_word("one", 32'h0000005A, 32'h5A000000, 1, 1);
    chk("last blk ir", 32'(a_ir), 0);
    setin(8'h77, 0, 1, 0);
    #1 chk("last blk nov ir", 32'(a_ir), 0);
    setin(8'h77, 0, 0, 0);
    #1 chk("nolast ir", 32'(a_ir), 1);
    @(negedge clk);
    setin(8'h00, 0, 0, 1);
    @(negedge clk);

    // reset mid-word with a held word present
    setin(8'hAA, 1, 0, 0); @(negedge clk);
    setin(8'hBB, 1, 1, 0); @(negedge clk);
    setin(8'h01, 1, 0, 0); @(negedge clk);
    setin(8'h02, 1, 0, 0); @(negedge clk);
    setin(8'h00, 0, 0, 0);
    #2 chk("pre-rst ov", 32'(a_ov), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async a_ov", 32'(a_ov), 0);
    chk("async b_ov", 32'(b_ov), 0);
    chk("async a_D", a_d, 0);
    chk("async b_D", b_d, 0);
    chk("async a_nb", 32'(a_nb), 0);
    chk("async a_last", 32'(a_last), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post-rst ir", 32'(a_ir), 1);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      setin(8'(k), 1, 0, 1);
      @(negedge clk);
    end
    setin(8'h00, 0, 0, 1);
    #2 chk_word("post-rst", 32'h04030201, 32'h01020304, 4, 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
